// File: rtl/dpu_dispatch_scheduler_pkg.sv
// Shared DPU types: unit selector, scheduler FSM states and the registered request bundle.
package riscv_dpu_pkg;

  localparam int unsigned DPU_XLEN            = 32;
  localparam int unsigned DPU_TIMEOUT_DEFAULT = 256;

  typedef enum logic [1:0] {
    DPU_FPU  = 2'd0,
    DPU_VPU  = 2'd1,
    DPU_MLIU = 2'd2,
    DPU_RSVD = 2'd3
  } dpu_unit_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } dpu_sched_state_e;

  typedef struct packed {
    logic [6:0]          op;
    logic [DPU_XLEN-1:0] operand_a;
    logic [DPU_XLEN-1:0] operand_b;
    logic [4:0]          rd;
    dpu_unit_e           unit;
  } dpu_req_t;

  function automatic logic [2:0] dpu_unit_onehot(input dpu_unit_e unit);
    logic [2:0] oh;
    oh = 3'b000;
    case (unit)
      DPU_FPU:  oh = 3'b001;
      DPU_VPU:  oh = 3'b010;
      DPU_MLIU: oh = 3'b100;
      default:  oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dpu_dispatch_scheduler_if.sv
// Issue/result bus between the dispatch scheduler and the three shared DPU units.
interface dpu_dispatch_scheduler_if #(
  parameter int unsigned XLEN = 32
);
  logic [2:0]        valid;
  logic [2:0]        ready;
  logic [6:0]        op;
  logic [XLEN-1:0]   operand_a;
  logic [XLEN-1:0]   operand_b;
  logic [2:0]        result_valid;
  logic [3*XLEN-1:0] result;

  modport master (
    output valid, op, operand_a, operand_b,
    input  ready, result_valid, result
  );

  modport slave (
    input  valid, op, operand_a, operand_b,
    output ready, result_valid, result
  );
endinterface

// File: rtl/dpu_dispatch_scheduler_watchdog.sv
// Per-operation cycle watchdog with a saturating count of expiry events.
module dpu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        enable_i,
  output logic        expire_o,
  output logic [15:0] event_count_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_next;
  logic [15:0]     r_events;

  // Expiry is judged on the next count so the owner sees it one cycle before the limit.
  assign w_cnt_next    = r_cnt + CntW'(1);
  assign expire_o      = enable_i && (w_cnt_next == CntW'(TIMEOUT_CYCLES - 1));
  assign event_count_o = r_events;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_events <= '0;
    end else begin
      if (clear_i) begin
        r_cnt <= '0;
      end else if (enable_i) begin
        r_cnt <= w_cnt_next;
      end
      if (expire_o && (r_events != 16'hFFFF)) begin
        r_events <= r_events + 16'd1;
      end
    end
  end

endmodule

// File: rtl/dpu_dispatch_scheduler.sv
// Issues one Execute-stage op at a time to FPU/VPU/MLIU and returns its result to writeback.
module dpu_dispatch_scheduler
  import riscv_dpu_pkg::*;
#(
  parameter int unsigned XLEN           = DPU_XLEN,
  parameter int unsigned TIMEOUT_CYCLES = DPU_TIMEOUT_DEFAULT
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_unit_sel_i,
  input  logic [6:0]                req_op_i,
  input  logic [XLEN-1:0]           req_operand_a_i,
  input  logic [XLEN-1:0]           req_operand_b_i,
  input  logic [4:0]                req_rd_addr_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  dpu_dispatch_scheduler_if.master  unit_if,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [4:0]                wb_rd_addr_o,
  output logic [XLEN-1:0]           wb_data_o,
  output logic                      wb_error_o,
  output logic [15:0]               timeout_count_o
);

  dpu_sched_state_e r_state, w_state_d;
  dpu_req_t         r_req, w_req_d;
  logic [2:0]       r_unit_valid, w_unit_valid_d;
  logic             r_wb_valid, w_wb_valid_d;
  logic             r_wb_error, w_wb_error_d;
  logic [XLEN-1:0]  r_wb_data, w_wb_data_d;
  logic [4:0]       r_wb_rd, w_wb_rd_d;
  logic             r_kill, w_kill_d;

  logic             w_accept, w_expire, w_kill, w_handshake, w_result_hit;
  logic             w_wd_clear, w_wd_enable;
  logic [XLEN-1:0]  w_sel_result;

  assign req_ready_o = (r_state == StIdle) && !flush_i;
  assign w_accept    = req_valid_i && req_ready_o;
  assign stall_o     = (r_state != StIdle) || (req_valid_i && !req_ready_o);
  assign w_kill      = r_kill || flush_i;
  assign w_handshake = |(r_unit_valid & unit_if.ready);
  assign w_wd_clear  = (r_state == StIdle);
  assign w_wd_enable = (r_state == StIssue) || (r_state == StWait);

  assign unit_if.valid     = r_unit_valid;
  assign unit_if.op        = r_req.op;
  assign unit_if.operand_a = r_req.operand_a;
  assign unit_if.operand_b = r_req.operand_b;
  assign wb_valid_o        = r_wb_valid;
  assign wb_rd_addr_o      = r_wb_rd;
  assign wb_data_o         = r_wb_data;
  assign wb_error_o        = r_wb_error;

  // Strobes from units other than the selected one never reach the FSM.
  always_comb begin
    w_sel_result = '0;
    w_result_hit = 1'b0;
    case (r_req.unit)
      DPU_FPU:  begin w_sel_result = unit_if.result[0*XLEN +: XLEN];
                      w_result_hit = unit_if.result_valid[0]; end
      DPU_VPU:  begin w_sel_result = unit_if.result[1*XLEN +: XLEN];
                      w_result_hit = unit_if.result_valid[1]; end
      DPU_MLIU: begin w_sel_result = unit_if.result[2*XLEN +: XLEN];
                      w_result_hit = unit_if.result_valid[2]; end
      default:  ;
    endcase
  end

  dpu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (w_wd_clear),
    .enable_i     (w_wd_enable),
    .expire_o     (w_expire),
    .event_count_o(timeout_count_o)
  );

  always_comb begin
    w_state_d      = r_state;
    w_req_d        = r_req;
    w_unit_valid_d = r_unit_valid;
    w_wb_valid_d   = r_wb_valid;
    w_wb_error_d   = r_wb_error;
    w_wb_data_d    = r_wb_data;
    w_wb_rd_d      = r_wb_rd;
    w_kill_d       = r_kill;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_req_d.op        = req_op_i;
          w_req_d.operand_a = req_operand_a_i;
          w_req_d.operand_b = req_operand_b_i;
          w_req_d.rd        = req_rd_addr_i;
          w_req_d.unit      = dpu_unit_e'(req_unit_sel_i);
          if (dpu_unit_e'(req_unit_sel_i) == DPU_RSVD) begin
            w_state_d    = StResp;
            w_wb_valid_d = 1'b1;
            w_wb_error_d = 1'b1;
            w_wb_data_d  = '0;
            w_wb_rd_d    = req_rd_addr_i;
          end else begin
            w_state_d      = StIssue;
            w_unit_valid_d = dpu_unit_onehot(dpu_unit_e'(req_unit_sel_i));
          end
        end
      end
      StIssue: begin
        w_kill_d = w_kill;
        if (w_expire) begin
          w_unit_valid_d = '0;
          if (w_kill) begin
            w_state_d = StIdle;
          end else begin
            w_state_d    = StResp;
            w_wb_valid_d = 1'b1;
            w_wb_error_d = 1'b1;
            w_wb_data_d  = '0;
            w_wb_rd_d    = r_req.rd;
          end
        end else if (w_handshake) begin
          w_unit_valid_d = '0;
          w_state_d      = StWait;
        end
      end
      StWait: begin
        w_kill_d = w_kill;
        if (w_result_hit || w_expire) begin
          if (w_kill) begin
            w_state_d = StIdle;
          end else begin
            w_state_d    = StResp;
            w_wb_valid_d = 1'b1;
            w_wb_error_d = !w_result_hit;
            w_wb_data_d  = w_result_hit ? w_sel_result : '0;
            w_wb_rd_d    = r_req.rd;
          end
        end
      end
      StResp: begin
        if (wb_ready_i) begin
          w_state_d    = StIdle;
          w_wb_valid_d = 1'b0;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_state_d == StIdle) w_kill_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_req        <= '0;
      r_unit_valid <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_error   <= 1'b0;
      r_wb_data    <= '0;
      r_wb_rd      <= '0;
      r_kill       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_req        <= w_req_d;
      r_unit_valid <= w_unit_valid_d;
      r_wb_valid   <= w_wb_valid_d;
      r_wb_error   <= w_wb_error_d;
      r_wb_data    <= w_wb_data_d;
      r_wb_rd      <= w_wb_rd_d;
      r_kill       <= w_kill_d;
    end
  end

endmodule

// File: tb/tb_dpu_dispatch_scheduler.sv
// Directed bench for the DPU dispatch scheduler with a writeback scoreboard.
module tb_dpu_dispatch_scheduler;
  import riscv_dpu_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TMO  = 16;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            req_valid_i, req_ready_o, flush_i, stall_o;
  logic [1:0]      req_unit_sel_i;
  logic [6:0]      req_op_i;
  logic [XLEN-1:0] req_operand_a_i, req_operand_b_i;
  logic [4:0]      req_rd_addr_i;
  logic            wb_valid_o, wb_ready_i, wb_error_o;
  logic [4:0]      wb_rd_addr_o;
  logic [XLEN-1:0] wb_data_o;
  logic [15:0]     timeout_count_o;

  always #5 clk = ~clk;

  dpu_dispatch_scheduler_if #(.XLEN(XLEN)) u_if ();

  dpu_dispatch_scheduler #(
    .XLEN          (XLEN),
    .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_unit_sel_i (req_unit_sel_i),
    .req_op_i       (req_op_i),
    .req_operand_a_i(req_operand_a_i),
    .req_operand_b_i(req_operand_b_i),
    .req_rd_addr_i  (req_rd_addr_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .unit_if        (u_if.master),
    .wb_valid_o     (wb_valid_o),
    .wb_ready_i     (wb_ready_i),
    .wb_rd_addr_o   (wb_rd_addr_o),
    .wb_data_o      (wb_data_o),
    .wb_error_o     (wb_error_o),
    .timeout_count_o(timeout_count_o)
  );

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            err;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [XLEN-1:0] data, input logic err);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  task automatic drive_req(input int sel, input logic [6:0] op, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [4:0] rd);
    req_valid_i     = 1'b1;
    req_unit_sel_i  = 2'(sel);
    req_op_i        = op;
    req_operand_a_i = a;
    req_operand_b_i = b;
    req_rd_addr_i   = rd;
  endtask

  // Writeback monitor: every completed handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst_i && wb_valid_o && wb_ready_i) begin
      if (sb_q.size() == 0) begin
        check_eq("wb_unexpected", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("wb_rd", 64'(wb_rd_addr_o), 64'(e.rd));
        check_eq("wb_data", 64'(wb_data_o), 64'(e.data));
        check_eq("wb_error", 64'(wb_error_o), 64'(e.err));
      end
    end
  end

  // Best-case op: accept N, issue N+1 with immediate ready, result N+2, writeback N+3.
  task automatic fast_op(input int sel, input logic [4:0] rd, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] res);
    logic [2:0] oh;
    oh = 3'b001 << sel;
    drive_req(sel, 7'h01, a, b, rd);
    #1;
    check_eq("fast_accept", 64'(req_ready_o), 64'd1);
    check_eq("fast_stall_n0", 64'(stall_o), 64'd0);
    push_exp(rd, res, 1'b0);
    tick();
    req_valid_i = 1'b0;
    check_eq("fast_unit_valid", 64'(u_if.valid), 64'(oh));
    check_eq("fast_operand_a", 64'(u_if.operand_a), 64'(a));
    check_eq("fast_operand_b", 64'(u_if.operand_b), 64'(b));
    check_eq("fast_stall_n1", 64'(stall_o), 64'd1);
    u_if.ready = oh;
    tick();
    u_if.ready = 3'b000;
    check_eq("fast_valid_drop", 64'(u_if.valid), 64'd0);
    check_eq("fast_wb_early", 64'(wb_valid_o), 64'd0);
    u_if.result_valid = oh;
    u_if.result = '0;
    u_if.result[sel*XLEN +: XLEN] = res;
    tick();
    u_if.result_valid = 3'b000;
    check_eq("fast_wb_valid", 64'(wb_valid_o), 64'd1);
    check_eq("fast_stall_n3", 64'(stall_o), 64'd1);
    tick();
    check_eq("fast_wb_done", 64'(wb_valid_o), 64'd0);
    check_eq("fast_idle_ready", 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b0; req_unit_sel_i = '0; req_op_i = '0;
    req_operand_a_i = '0; req_operand_b_i = '0; req_rd_addr_i = '0; flush_i = 1'b0;
    wb_ready_i = 1'b1; u_if.ready = '0; u_if.result_valid = '0; u_if.result = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    #1;
    check_eq("rst_unit_valid", 64'(u_if.valid), 64'd0);
    check_eq("rst_unit_op", 64'(u_if.op), 64'd0);
    check_eq("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check_eq("rst_wb_error", 64'(wb_error_o), 64'd0);
    check_eq("rst_wb_data", 64'(wb_data_o), 64'd0);
    check_eq("rst_wb_rd", 64'(wb_rd_addr_o), 64'd0);
    check_eq("rst_tmo_count", 64'(timeout_count_o), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready_o), 64'd1);
    check_eq("rst_stall", 64'(stall_o), 64'd0);
    tick();

    // FPU best case.
    fast_op(0, 5'd5, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);

    // VPU: ready after 5 cycles of valid, writeback back-pressured 3 cycles.
    drive_req(1, 7'h22, 32'hAAAA_5555, 32'h0F0F_0F0F, 5'd9);
    push_exp(5'd9, 32'h1234_5678, 1'b0);
    tick();
    drive_req(0, 7'h33, 32'h1111_1111, 32'h2222_2222, 5'd1);
    #1;
    for (int k = 1; k <= 5; k++) begin
      check_eq("vpu_valid_hold", 64'(u_if.valid), 64'b010);
      check_eq("vpu_op_hold", 64'(u_if.op), 64'h22);
      check_eq("vpu_a_hold", 64'(u_if.operand_a), 64'hAAAA_5555);
      check_eq("vpu_b_hold", 64'(u_if.operand_b), 64'h0F0F_0F0F);
      check_eq("vpu_no_accept", 64'(req_ready_o), 64'd0);
      check_eq("vpu_stall", 64'(stall_o), 64'd1);
      if (k == 5) u_if.ready = 3'b010;
      tick();
    end
    u_if.ready = 3'b000;
    check_eq("vpu_valid_drop", 64'(u_if.valid), 64'd0);
    u_if.result_valid = 3'b010;
    u_if.result = '0;
    u_if.result[XLEN +: XLEN] = 32'h1234_5678;
    wb_ready_i = 1'b0;
    tick();
    u_if.result_valid = 3'b000;
    for (int k = 0; k < 3; k++) begin
      check_eq("vpu_wb_hold", 64'(wb_valid_o), 64'd1);
      check_eq("vpu_rd_hold", 64'(wb_rd_addr_o), 64'd9);
      check_eq("vpu_data_hold", 64'(wb_data_o), 64'h1234_5678);
      check_eq("vpu_no_accept_wb", 64'(req_ready_o), 64'd0);
      if (k == 2) begin
        wb_ready_i  = 1'b1;
        req_valid_i = 1'b0;
      end
      tick();
    end
    check_eq("vpu_wb_done", 64'(wb_valid_o), 64'd0);
    check_eq("vpu_no_second_op", 64'(u_if.valid), 64'd0);

    // MLIU hang: watchdog completion with error.
    drive_req(2, 7'h05, 32'h1, 32'h2, 5'd17);
    push_exp(5'd17, '0, 1'b1);
    tick();
    req_valid_i = 1'b0;
    u_if.ready  = 3'b100;
    tick();
    u_if.ready = 3'b000;
    for (int k = 2; k < int'(TMO); k++) begin
      check_eq("tmo_wait", 64'(wb_valid_o), 64'd0);
      tick();
    end
    check_eq("tmo_wb_valid", 64'(wb_valid_o), 64'd1);
    check_eq("tmo_wb_error", 64'(wb_error_o), 64'd1);
    check_eq("tmo_wb_data", 64'(wb_data_o), 64'd0);
    check_eq("tmo_count", 64'(timeout_count_o), 64'd1);
    tick();

    // Reserved unit: immediate error completion, no issue.
    drive_req(3, 7'h07, 32'h5, 32'h6, 5'd12);
    push_exp(5'd12, '0, 1'b1);
    #1;
    check_eq("rsvd_accept", 64'(req_ready_o), 64'd1);
    tick();
    req_valid_i = 1'b0;
    check_eq("rsvd_wb_valid", 64'(wb_valid_o), 64'd1);
    check_eq("rsvd_wb_error", 64'(wb_error_o), 64'd1);
    check_eq("rsvd_no_issue", 64'(u_if.valid), 64'd0);
    tick();
    check_eq("rsvd_done", 64'(wb_valid_o), 64'd0);

    // Flush during WAIT: result dropped, back to IDLE.
    drive_req(0, 7'h09, 32'h7, 32'h8, 5'd3);
    tick();
    req_valid_i = 1'b0;
    u_if.ready  = 3'b001;
    tick();
    u_if.ready = 3'b000;
    flush_i    = 1'b1;
    tick();
    flush_i           = 1'b0;
    u_if.result_valid = 3'b001;
    u_if.result       = '0;
    u_if.result[0 +: XLEN] = 32'hDEAD_BEEF;
    #1;
    check_eq("flush_wait_stall", 64'(stall_o), 64'd1);
    tick();
    u_if.result_valid = 3'b000;
    check_eq("flush_no_wb", 64'(wb_valid_o), 64'd0);
    check_eq("flush_idle", 64'(req_ready_o), 64'd1);
    fast_op(1, 5'd7, 32'hCAFE_0000, 32'h0000_F00D, 32'h0BAD_F00D);

    // Flush in IDLE blocks acceptance for that cycle.
    drive_req(0, 7'h0A, 32'h9, 32'hA, 5'd20);
    flush_i = 1'b1;
    #1;
    check_eq("idle_flush_ready", 64'(req_ready_o), 64'd0);
    check_eq("idle_flush_stall", 64'(stall_o), 64'd1);
    tick();
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    check_eq("idle_flush_no_issue", 64'(u_if.valid), 64'd0);
    tick();
    fast_op(2, 5'd21, 32'h1357_9BDF, 32'h2468_ACE0, 32'h7777_0001);

    // Spurious VPU strobe while waiting on FPU.
    drive_req(0, 7'h0B, 32'h11, 32'h22, 5'd14);
    push_exp(5'd14, 32'h0000_1234, 1'b0);
    tick();
    req_valid_i = 1'b0;
    u_if.ready  = 3'b001;
    tick();
    u_if.ready        = 3'b000;
    u_if.result_valid = 3'b010;
    u_if.result       = '0;
    u_if.result[XLEN +: XLEN] = 32'hBAD0_BAD0;
    tick();
    check_eq("spur_ignored", 64'(wb_valid_o), 64'd0);
    u_if.result_valid = 3'b001;
    u_if.result[0 +: XLEN] = 32'h0000_1234;
    tick();
    u_if.result_valid = 3'b000;
    check_eq("spur_wb_valid", 64'(wb_valid_o), 64'd1);
    tick();

    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    check_eq("final_tmo_count", 64'(timeout_count_o), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
